fifo_ctrl_lvl: RTL and testbench

Parametrised FIFO pointer/flag controller, next generation of the UART FIFO control logic. Generates write/read addresses for an external 2^ADDR_WIDTH-entry register file. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and accept strobes for the storage array. Sits between the UART RX/TX datapaths and their buffer memories.

---
 rtl/fifo_ctrl_lvl.sv | 115 +++++++++++
 tb/tb_fifo_ctrl_lvl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_lvl.sv
// FIFO pointer/flag controller with occupancy level, almost-full/empty thresholds and flush.
// Define FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_ctrl_lvl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;

    // Accept strobes: full+read is safe because read data is sampled before the edge.
    assign wr_en = reset_n & ~flush & wr & (~full_q | rd);
    assign rd_en = reset_n & ~flush & rd & ~empty_q;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            level_d = '0;
        end else begin
            if (wr_en) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
            if (rd_en) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
            level_d = level_q + LW'(wr_en) - LW'(rd_en);
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
        af_d    = (level_d >= LW'(AF_LEVEL));
        ae_d    = (level_d <= LW'(AE_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    assign w_addr       = w_ptr_q;
    assign r_addr       = r_ptr_q;
    assign level        = level_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error flags; a new event wins over err_clr in the same cycle.
    always_comb begin
        ovf_d = (ovf_q & ~err_clr) | (wr & ~wr_en & ~flush);
        unf_d = (unf_q & ~err_clr) | (rd & ~rd_en & ~flush);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_lvl.sv
// Self-checking bench for fifo_ctrl_lvl: directed scenarios plus random traffic against an occupancy model.
module tb_fifo_ctrl_lvl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic wr = 1'b0, rd = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic wr_en, rd_en, full, empty, almost_full, almost_empty;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   level;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow, underflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int m_lvl = 0, m_w = 0, m_r = 0;
    bit m_ovf = 0, m_unf = 0;

    fifo_ctrl_lvl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .flush        (flush),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        check("level", 32'(level), 32'(m_lvl));
        check("w_addr", 32'(w_addr), 32'(m_w));
        check("r_addr", 32'(r_addr), 32'(m_r));
        check("full", 32'(full), 32'(m_lvl == DEPTH));
        check("empty", 32'(empty), 32'(m_lvl == 0));
        check("almost_full", 32'(almost_full), 32'(m_lvl >= AF));
        check("almost_empty", 32'(almost_empty), 32'(m_lvl <= AE));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`endif
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_reset(input logic w);
        reset_n = 1'b0; wr = w; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        m_lvl = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0;
        #1;
        check_state();
        reset_n = 1'b1; wr = 1'b0;
    endtask

    task automatic step(input logic w, input logic r, input logic f, input logic c);
        bit ew, er;
        wr = w; rd = r; flush = f; err_clr = c;
        ew = !f && w && (m_lvl < DEPTH || r);
        er = !f && r && (m_lvl > 0);
        @(negedge clk);
        check("wr_en", 32'(wr_en), 32'(ew));
        check("rd_en", 32'(rd_en), 32'(er));
        @(posedge clk);
        m_ovf = (m_ovf && !c) || (!f && w && !ew);
        m_unf = (m_unf && !c) || (!f && r && !er);
        if (f) begin
            m_lvl = 0; m_w = 0; m_r = 0;
        end else begin
            if (ew) begin m_w = (m_w + 1) % DEPTH; m_lvl++; end
            if (er) begin m_r = (m_r + 1) % DEPTH; m_lvl--; end
        end
        #1;
        check_state();
        wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        int pw;
        @(posedge clk); #1;
        do_reset(1'b0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 0, 0);
            check("fill_level", 32'(level), 32'(i + 1));
            check("fill_ae", 32'(almost_empty), 32'(i + 1 <= 2));
            check("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
        end
        check("fill_full", 32'(full), 32'd1);
        step(1, 0, 0, 0);
        check("ovf_waddr", 32'(w_addr), 32'd0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        check("ovf_flag", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("full_rw_level", 32'(level), 32'd8);
        check("full_rw_waddr", 32'(w_addr), 32'd3);
        check("full_rw_raddr", 32'(r_addr), 32'd3);
        step(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
        check("drain_empty", 32'(empty), 32'd1);
        step(1, 1, 0, 0);
        check("empty_rw_level", 32'(level), 32'd1);
        check("empty_rw_empty", 32'(empty), 32'd0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        check("unf_flag", 32'(underflow), 32'd1);
        step(0, 0, 0, 1);
        check("unf_clr", 32'(underflow), 32'd0);
`endif

        do_reset(1'b0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
            for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
            check("wrap_level", 32'(level), 32'd0);
            check("wrap_empty", 32'(empty), 32'd1);
        end
        check("wrap_raddr", 32'(r_addr), 32'd2);

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_waddr", 32'(w_addr), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        do_reset(1'b1);
        check("midrst_level", 32'(level), 32'd0);

        pw = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) pw = int'($urandom_range(10, 90));
            if ($urandom_range(0, 255) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                step(1'(int'($urandom_range(0, 99)) < pw),
                     1'(int'($urandom_range(0, 99)) >= pw),
                     1'($urandom_range(0, 63) == 0),
                     1'($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
